// File: rtl/uart_rx_bit_timer.sv
// UART RX bit timer: counts oversampling edges per bit and bits per frame,
// and decodes the centre sample window, bit-end and frame-done strobes.
// Prescale and frame length are captured at frame start. An illegal
// configuration parks the block in an error state until enable drops.
module uart_rx_bit_timer #(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic [BIT_CNT_W-1:0] frame_len,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sample_strb,
  output logic                 mid_strb,
  output logic                 bit_end,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [PRESC_W-1:0]   ONE_P     = PRESC_W'(1);
  localparam logic [PRESC_W-1:0]   PRESC_MIN = PRESC_W'(4);
  localparam logic [BIT_CNT_W-1:0] ONE_B     = BIT_CNT_W'(1);

  state_t               state, state_nxt;
  logic [PRESC_W-1:0]   presc_q, presc_nxt;
  logic [BIT_CNT_W-1:0] len_q, len_nxt;
  logic [PRESC_W-1:0]   edge_nxt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic [PRESC_W-1:0]   half;
  logic                 edge_last;
  logic                 bit_last;

  // Position compares against the latched frame shape. Legality is checked
  // before RUN, so presc_q-1 and len_q-1 never wrap while they matter.
  assign half      = presc_q >> 1;
  assign edge_last = (edge_cnt == presc_q - ONE_P);
  assign bit_last  = (bit_cnt == len_q - ONE_B);

  // State, counter and configuration registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      presc_q  <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= edge_nxt;
      bit_cnt  <= bit_nxt;
      presc_q  <= presc_nxt;
      len_q    <= len_nxt;
    end
  end

  // Next-state logic: frame start/latch, edge/bit counting, abort and parking.
  always_comb begin
    state_nxt = state;
    edge_nxt  = edge_cnt;
    bit_nxt   = bit_cnt;
    presc_nxt = presc_q;
    len_nxt   = len_q;
    case (state)
      IDLE: begin
        edge_nxt = '0;
        bit_nxt  = '0;
        if (enable) begin
          presc_nxt = prescale;
          len_nxt   = frame_len;
          if ((prescale < PRESC_MIN) || (frame_len == '0)) begin
            state_nxt = ERR;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort: drop the frame without a completion pulse on the next cycle.
          state_nxt = IDLE;
          edge_nxt  = '0;
          bit_nxt   = '0;
        end else if (edge_last) begin
          edge_nxt = '0;
          if (bit_last) begin
            bit_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            bit_nxt = bit_cnt + ONE_B;
          end
        end else begin
          edge_nxt = edge_cnt + ONE_P;
        end
      end
      HOLD, ERR: begin
        // Wait for the RX FSM to release enable; no automatic restart.
        edge_nxt = '0;
        bit_nxt  = '0;
        if (!enable) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        edge_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Output decodes from registered state and counters, active only in RUN.
  always_comb begin
    sample_strb = 1'b0;
    mid_strb    = 1'b0;
    bit_end     = 1'b0;
    frame_done  = 1'b0;
    busy        = (state == RUN);
    cfg_err     = (state == ERR);
    if (state == RUN) begin
      sample_strb = (edge_cnt == half - ONE_P) || (edge_cnt == half) ||
                    (edge_cnt == half + ONE_P);
      mid_strb    = (edge_cnt == half);
      bit_end     = edge_last;
      frame_done  = edge_last && bit_last;
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Testbench for uart_rx_bit_timer: fixed vector table, directed frame
// sequences and randomized traffic against a frame-position reference model.
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          CLK;
  logic          RST;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_len;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_strb, mid_strb, bit_end, frame_done, busy, cfg_err;

  int vectors;
  int miscompares;

  // Reference model: mode 0 idle, 1 run, 2 hold, 3 err; t = RUN cycle index in frame.
  int m_mode, m_p, m_l, m_t;

  uart_rx_bit_timer #(.PRESC_W(PW), .BIT_CNT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .prescale(prescale),
    .frame_len(frame_len), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_strb(sample_strb), .mid_strb(mid_strb), .bit_end(bit_end),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          en;
    logic [PW-1:0] p;
    logic [BW-1:0] l;
    logic [15:0]   exp;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [15:0] pk(input int e, input int b, input bit s, input bit m,
                                     input bit be, input bit fd, input bit bs, input bit er);
    logic [PW-1:0] ev;
    logic [BW-1:0] bv;
    ev = PW'(e);
    bv = BW'(b);
    return {ev, bv, s, m, be, fd, bs, er};
  endfunction

  function automatic logic [15:0] dut_out();
    return {edge_cnt, bit_cnt, sample_strb, mid_strb, bit_end, frame_done, busy, cfg_err};
  endfunction

  function automatic logic [15:0] model_out();
    int e, b, h;
    if (m_mode == 1) begin
      e = m_t % m_p;
      b = m_t / m_p;
      h = m_p / 2;
      return pk(e, b, (e >= h - 1) && (e <= h + 1), e == h, e == m_p - 1,
                m_t == m_p * m_l - 1, 1'b1, 1'b0);
    end
    return pk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_mode == 3);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_l = 0; m_t = 0;
  endtask

  task automatic model_clock(input bit en, input int p, input int l);
    case (m_mode)
      0: if (en) begin
        m_p = p; m_l = l; m_t = 0;
        m_mode = (p < 4 || l == 0) ? 3 : 1;
      end
      1: begin
        if (!en) begin
          m_mode = 0; m_t = 0;
        end else if (m_t == m_p * m_l - 1) begin
          m_mode = 2; m_t = 0;
        end else begin
          m_t = m_t + 1;
        end
      end
      default: if (!en) m_mode = 0;
    endcase
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {edge,bit,s,m,be,fd,busy,err}=%h required %h",
               name, $time, got, exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic cycle(input string name, input bit en, input int p, input int l);
    enable = en; prescale = PW'(p); frame_len = BW'(l);
    @(posedge CLK);
    model_clock(en, p, l);
    #1;
    cmp(name, dut_out(), model_out());
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; enable = 1'b0;
    #1;
    model_reset();
    cmp("reset_state", dut_out(), model_out());
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_vec(input int i, input bit en, input int p, input int l, input logic [15:0] exp);
    tbl[i].en = en; tbl[i].p = PW'(p); tbl[i].l = BW'(l); tbl[i].exp = exp;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RST = 1'b1; enable = 1'b0; prescale = '0; frame_len = '0;
    model_reset();

    // ---- vector table: prescale=5/len=1, illegal configs, prescale=4 abort
    set_vec(0,  1, 5, 1, pk(0,0,0,0,0,0,1,0));
    set_vec(1,  1, 5, 1, pk(1,0,1,0,0,0,1,0));
    set_vec(2,  1, 5, 1, pk(2,0,1,1,0,0,1,0));
    set_vec(3,  1, 5, 1, pk(3,0,1,0,0,0,1,0));
    set_vec(4,  1, 5, 1, pk(4,0,0,0,1,1,1,0));
    set_vec(5,  1, 5, 1, pk(0,0,0,0,0,0,0,0));
    set_vec(6,  1, 5, 1, pk(0,0,0,0,0,0,0,0));
    set_vec(7,  0, 5, 1, pk(0,0,0,0,0,0,0,0));
    set_vec(8,  1, 3, 4, pk(0,0,0,0,0,0,0,1));
    set_vec(9,  1, 8, 4, pk(0,0,0,0,0,0,0,1));
    set_vec(10, 0, 8, 4, pk(0,0,0,0,0,0,0,0));
    set_vec(11, 1, 8, 0, pk(0,0,0,0,0,0,0,1));
    set_vec(12, 0, 8, 0, pk(0,0,0,0,0,0,0,0));
    set_vec(13, 1, 4, 2, pk(0,0,0,0,0,0,1,0));
    set_vec(14, 1, 4, 2, pk(1,0,1,0,0,0,1,0));
    set_vec(15, 1, 4, 2, pk(2,0,1,1,0,0,1,0));
    set_vec(16, 1, 4, 2, pk(3,0,1,0,1,0,1,0));
    set_vec(17, 1, 4, 2, pk(0,1,0,0,0,0,1,0));
    set_vec(18, 0, 4, 2, pk(0,0,0,0,0,0,0,0));

    #1;
    cmp("in_reset", dut_out(), pk(0,0,0,0,0,0,0,0));
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    cmp("after_reset", dut_out(), pk(0,0,0,0,0,0,0,0));

    for (int i = 0; i < 19; i++) begin
      enable = tbl[i].en; prescale = tbl[i].p; frame_len = tbl[i].l;
      @(posedge CLK);
      #1;
      cmp($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    // ---- prescale=8, frame_len=10, full frame
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      cycle("p8_frame", 1'b1, 8, 10);
      if (n == 80) begin
        chk("p8_fdone_cycle80", int'(frame_done), 1);
        chk("p8_bit_at_fdone", int'(bit_cnt), 9);
      end
    end
    cycle("p8_hold", 1'b1, 8, 10);
    chk("p8_hold_busy", int'(busy), 0);
    cycle("p8_release", 1'b0, 8, 10);

    // ---- abort at bit 3 edge 2
    for (int n = 1; n <= 27; n++) cycle("abort_run", 1'b1, 8, 10);
    chk("abort_pos_bit", int'(bit_cnt), 3);
    chk("abort_pos_edge", int'(edge_cnt), 2);
    cycle("abort_drop", 1'b0, 8, 10);
    chk("abort_busy", int'(busy), 0);
    for (int n = 0; n < 4; n++) cycle("abort_idle", 1'b0, 8, 10);

    // ---- prescale change mid-frame is ignored until the next frame
    for (int n = 1; n <= 48; n++) begin
      cycle("cfg_keep16", 1'b1, (n > 33) ? 8 : 16, 3);
      if (n == 48) chk("cfg_fdone16", int'(frame_done), 1);
    end
    cycle("cfg_hold", 1'b1, 8, 3);
    cycle("cfg_release", 1'b0, 8, 3);
    for (int n = 1; n <= 24; n++) begin
      cycle("cfg_use8", 1'b1, 8, 3);
      if (n == 24) chk("cfg_fdone8", int'(frame_done), 1);
    end
    cycle("cfg_hold2", 1'b0, 8, 3);

    // ---- async reset at bit 4 mid-frame
    for (int n = 1; n <= 8 * 4 + 3; n++) cycle("rst_run", 1'b1, 8, 10);
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    cmp("async_rst_outputs", dut_out(), pk(0,0,0,0,0,0,0,0));
    #2;
    RST = 1'b0;
    cycle("rst_restart", 1'b1, 8, 10);
    chk("rst_restart_busy", int'(busy), 1);
    for (int n = 0; n < 10; n++) cycle("rst_run2", 1'b1, 8, 10);
    cycle("rst_stop", 1'b0, 8, 10);

    // ---- randomized traffic
    begin
      int p, l;
      bit en;
      p = 6; l = 2;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(3, 10));
          l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
        end
        if (m_mode == 1) en = ($urandom_range(0, 99) != 0);
        else en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 299) == 0) begin
          enable = en; prescale = PW'(p); frame_len = BW'(l);
          #3;
          RST = 1'b1;
          #1;
          model_reset();
          cmp("rand_async_rst", dut_out(), model_out());
          #2;
          RST = 1'b0;
        end
        cycle("random", en, p, l);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
